// File: rtl/dl_regfile_oh_2r1w.sv
// Register file, 2 read / 1 write, one-hot write select, register 0 reads as zero.
// Latency: reads are combinational (0 cycles), writes land at the next rising edge; wr_err is 1 cycle after the bad write.
// Backpressure: none; a write can be presented every cycle and is never stalled.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   wr_en/wr_sel/wr_data - write request, one-hot register select, write data
//   rd_addrN/rd_dataN    - two independent combinational read ports (N = 0, 1)
//   wr_err               - one-cycle pulse after a write whose select was not one-hot
//   wr_err_sticky        - latched copy of wr_err, cleared only by reset
module dl_regfile_oh_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int BYPASS     = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [NUM_REGS-1:0]         wr_sel,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr0,
    input  logic [$clog2(NUM_REGS)-1:0] rd_addr1,
    output logic [DATA_WIDTH-1:0]       rd_data0,
    output logic [DATA_WIDTH-1:0]       rd_data1,
    output logic                        wr_err,
    output logic                        wr_err_sticky
);

    localparam int AW = $clog2(NUM_REGS);
    // Register count widened by one bit so out-of-range addresses can be compared without truncation.
    localparam logic [AW:0] NUM_W = (AW+1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic sel_any;
    logic sel_multi;
    logic sel_one_hot;
    logic wr_fire;
    logic wr_bad;

    // x & (x-1) clears the lowest set bit; anything left means two or more bits were set.
    assign sel_any     = |wr_sel;
    assign sel_multi   = |(wr_sel & (wr_sel - NUM_REGS'(1)));
    assign sel_one_hot = sel_any & ~sel_multi;

    // A write dropped by reset must neither update state nor be forwarded to the read ports.
    assign wr_fire = rst_n & wr_en & sel_one_hot;
    assign wr_bad  = wr_en & ~sel_one_hot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
            wr_err        <= 1'b0;
            wr_err_sticky <= 1'b0;
        end else begin
            // Entry 0 is never loaded, so a write selecting it is silently discarded.
            for (int k = 1; k < NUM_REGS; k++) begin
                if (wr_fire && wr_sel[k]) begin
                    regs[k] <= wr_data;
                end
            end
            wr_err        <= wr_bad;
            wr_err_sticky <= wr_err_sticky | wr_bad;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] rd_mux(input logic [AW-1:0] a);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        if ((a != '0) && ({1'b0, a} < NUM_W)) begin
            r = regs[a];
            if ((BYPASS != 0) && wr_fire && wr_sel[a]) begin
                r = wr_data;
            end
        end
        return r;
    endfunction

    always_comb begin
        rd_data0 = rd_mux(rd_addr0);
        rd_data1 = rd_mux(rd_addr1);
    end

endmodule

// File: tb/tb_dl_regfile_oh_2r1w.sv
module tb_dl_regfile_oh_2r1w;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_sel;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [4:0]  rd_addr1;
    logic [31:0] b_rd0, b_rd1, n_rd0, n_rd1;
    logic        b_err, b_sticky, n_err, n_sticky;

    always #5 clk = ~clk;

    dl_regfile_oh_2r1w #(.DATA_WIDTH(32), .NUM_REGS(32), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(b_rd0), .rd_data1(b_rd1),
        .wr_err(b_err), .wr_err_sticky(b_sticky)
    );

    dl_regfile_oh_2r1w #(.DATA_WIDTH(32), .NUM_REGS(32), .BYPASS(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(n_rd0), .rd_data1(n_rd1),
        .wr_err(n_err), .wr_err_sticky(n_sticky)
    );

    typedef struct {
        bit          chk;
        logic [31:0] b0, b1, n0, n1;
        logic        err, sticky;
    } exp_t;

    exp_t q[$];

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [31:0] m_regs [32];
    logic        m_err;
    logic        m_sticky;
    bit          m_known = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a, input bit byp, input bit legal,
                                             input logic [31:0] sel, input logic [31:0] data);
        if (a == 5'd0) return 32'h0;
        if (byp && legal && sel[a]) return data;
        return m_regs[a];
    endfunction

    // Apply one cycle of stimulus, queue what both instances must show this cycle, then advance the model.
    task automatic cyc(input bit rst, input bit en, input logic [31:0] sel, input logic [31:0] data,
                       input logic [4:0] a0, input logic [4:0] a1);
        exp_t e;
        bit   legal;
        rst_n    = rst;
        wr_en    = en;
        wr_sel   = sel;
        wr_data  = data;
        rd_addr0 = a0;
        rd_addr1 = a1;
        legal    = rst && en && ($countones(sel) == 1);
        e.chk    = m_known;
        e.b0     = model_rd(a0, 1'b1, legal, sel, data);
        e.b1     = model_rd(a1, 1'b1, legal, sel, data);
        e.n0     = model_rd(a0, 1'b0, legal, sel, data);
        e.n1     = model_rd(a1, 1'b0, legal, sel, data);
        e.err    = m_err;
        e.sticky = m_sticky;
        q.push_back(e);
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_err    = 1'b0;
            m_sticky = 1'b0;
            m_known  = 1;
        end else begin
            if (legal && !sel[0]) begin
                for (int i = 1; i < 32; i++) if (sel[i]) m_regs[i] = data;
            end
            m_err    = en && ($countones(sel) != 1);
            m_sticky = m_sticky || m_err;
        end
        #1;
    endtask

    task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, a0, a1);
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle away from the clock edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.chk) begin
                check("byp_rd_data0",  b_rd0, e.b0);
                check("byp_rd_data1",  b_rd1, e.b1);
                check("nobyp_rd_data0", n_rd0, e.n0);
                check("nobyp_rd_data1", n_rd1, e.n1);
                check("byp_wr_err",    {31'h0, b_err},    {31'h0, e.err});
                check("byp_sticky",    {31'h0, b_sticky}, {31'h0, e.sticky});
                check("nobyp_wr_err",  {31'h0, n_err},    {31'h0, e.err});
                check("nobyp_sticky",  {31'h0, n_sticky}, {31'h0, e.sticky});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_sel   = 32'h0;
        wr_data  = 32'h0;
        rd_addr0 = 5'd0;
        rd_addr1 = 5'd0;
        @(posedge clk);
        #1;

        // Reset: first cycle has unknown contents, second must show a clean file and flags.
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd1, 5'd2);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 5'd1, 5'd2);
        idle(5'd5, 5'd31);

        // Write sweep with forwarding visible on port 0, then all read pairs.
        for (int k = 1; k < 32; k++) begin
            cyc(1'b1, 1'b1, 32'h1 << k, 32'hA5A5_0000 + k, 5'(k), 5'(k - 1));
        end
        for (int k = 0; k < 32; k++) begin
            idle(5'(k), 5'(31 - k));
        end

        // Write to register 0: discarded, no error.
        cyc(1'b1, 1'b1, 32'h1, 32'hFFFF_FFFF, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd1);

        // Illegal multi-hot, then all-zero select, then back-to-back illegal writes.
        cyc(1'b1, 1'b1, 32'h0000_0006, 32'h1234_5678, 5'd1, 5'd2);
        idle(5'd1, 5'd2);
        idle(5'd1, 5'd2);
        cyc(1'b1, 1'b1, 32'h0, 32'h1234_5678, 5'd1, 5'd2);
        idle(5'd1, 5'd2);
        idle(5'd1, 5'd2);
        cyc(1'b1, 1'b1, 32'h8000_0001, 32'h0BAD_0001, 5'd31, 5'd0);
        cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0BAD_0002, 5'd31, 5'd1);
        idle(5'd31, 5'd1);
        idle(5'd31, 5'd1);

        // Select ignored while wr_en is low.
        cyc(1'b1, 1'b0, 32'h0000_0010, 32'h7777_7777, 5'd4, 5'd4);
        cyc(1'b1, 1'b0, 32'h0000_0030, 32'h7777_7777, 5'd4, 5'd5);
        idle(5'd4, 5'd5);

        // Forwarding: both ports on the register being written.
        cyc(1'b1, 1'b1, 32'h1 << 7, 32'hDEAD_BEEF, 5'd7, 5'd7);
        idle(5'd7, 5'd7);

        // Reset wins over a simultaneous legal write; reads still see pre-reset contents.
        cyc(1'b1, 1'b1, 32'h1 << 3, 32'h3333_0000, 5'd3, 5'd7);
        cyc(1'b0, 1'b1, 32'h1 << 3, 32'h5555_5555, 5'd3, 5'd3);
        idle(5'd3, 5'd7);
        idle(5'd3, 5'd7);

        // Random traffic with decoder-style selects, occasional illegal selects and gaps.
        for (int t = 0; t < 150; t++) begin
            int          gap;
            int          idx;
            int          r;
            logic [31:0] sel;
            gap = $urandom_range(0, 10);
            for (int g = 0; g < gap; g++) begin
                cyc(1'b1, 1'b0, $urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            end
            idx = $urandom_range(0, 31);
            sel = 32'h1 << idx;
            r   = $urandom_range(0, 7);
            if (r == 0) sel = 32'h0;
            else if (r == 1) sel = sel | (32'h1 << ((idx + 1 + $urandom_range(0, 30)) % 32));
            cyc(1'b1, $urandom_range(0, 3) != 0, sel, $urandom,
                (r == 2) ? 5'(idx) : 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        idle(5'd0, 5'd0);
        idle(5'd0, 5'd0);

        @(negedge clk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
